// File: rtl/task_in_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : task_in_frame_buffer
// Description : Frame-level input stage for task pipelines. Captures one
//               tlast-terminated input frame into a circular buffer, replays
//               it downstream with a valid/ready handshake, then waits for
//               the task core to signal completion before taking the next
//               frame. Reports frame length and sticky overflow.
//               Optional macro TASK_IN_FRAME_BUFFER_LAST_EN adds o_last.
// Revision    : 1.0 - initial release
// ============================================================================
module task_in_frame_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tvalid,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic                  i_tlast,
    output logic                  o_tready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    input  logic                  i_output_last,
    output logic [CNT_W-1:0]      o_frame_len,
    output logic                  o_overflow,
    output logic                  o_busy
`ifdef TASK_IN_FRAME_BUFFER_LAST_EN
    ,
    output logic                  o_last
`endif
);

    localparam int              PTR_W      = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_last_ptr  = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_SEND      = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_wr_cnt;
    logic [CNT_W-1:0]      r_issue_cnt;
    logic [CNT_W-1:0]      r_xfer_cnt;
    logic                  r_rd_vld;
    logic                  r_rd_last;
    logic                  r_pending_done;
    logic                  r_out_last;

    logic w_accept;
    logic w_drop;
    logic w_write;
    logic w_xfer;
    logic w_move;
    logic w_issue;
    logic w_last_xfer;
    logic w_restart;

    // Handshake qualifiers shared by the FSM and the datapath
    always_comb begin
        w_accept    = i_tvalid && o_tready;
        w_drop      = w_accept && (r_wr_cnt == c_depth_cnt);
        w_write     = w_accept && !w_drop;
        w_xfer      = o_valid && i_ready;
        // Read-data stage advances into the output register when that slot frees up
        w_move      = r_rd_vld && (!o_valid || i_ready);
        // Launch a RAM read only if the read-data stage will have room for it
        w_issue     = (r_state == S_SEND) && (r_issue_cnt < o_frame_len)
                      && (!r_rd_vld || w_move);
        w_last_xfer = w_xfer && (r_xfer_cnt == (o_frame_len - 1'b1));
        w_restart   = (r_state == S_WAIT_DONE) && (w_next_state == S_LOAD);
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        w_next_state = r_state;
        o_tready     = 1'b0;
        o_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_busy       = 1'b0;
                w_next_state = S_LOAD;
            end
            S_LOAD: begin
                o_tready = 1'b1;
                o_busy   = (r_wr_cnt != '0);
                if (w_accept && i_tlast) begin
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                if (w_last_xfer) begin
                    w_next_state = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (r_pending_done || i_output_last) begin
                    w_next_state = S_LOAD;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Buffer RAM: one write port, one registered read port
    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= i_tdata;
        end
        if (w_issue) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    // Capture counters, frame status and replay pipeline
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_wr_cnt       <= '0;
            r_issue_cnt    <= '0;
            r_xfer_cnt     <= '0;
            r_rd_vld       <= 1'b0;
            r_rd_last      <= 1'b0;
            r_pending_done <= 1'b0;
            r_out_last     <= 1'b0;
            o_valid        <= 1'b0;
            o_data         <= '0;
            o_frame_len    <= '0;
            o_overflow     <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end

            // Sticky until the first beat of the following frame arrives
            if (w_drop) begin
                o_overflow <= 1'b1;
            end else if (w_accept && (r_wr_cnt == '0)) begin
                o_overflow <= 1'b0;
            end

            // Frame length saturates at DEPTH because overflow beats are dropped
            if (w_accept && i_tlast) begin
                o_frame_len <= (r_wr_cnt == c_depth_cnt) ? c_depth_cnt : r_wr_cnt + 1'b1;
            end

            if (w_issue) begin
                r_rd_ptr    <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
                r_issue_cnt <= r_issue_cnt + 1'b1;
                r_rd_last   <= (r_issue_cnt == (o_frame_len - 1'b1));
                r_rd_vld    <= 1'b1;
            end else if (w_move) begin
                r_rd_vld    <= 1'b0;
            end

            if (w_move) begin
                o_valid    <= 1'b1;
                o_data     <= r_rd_data;
                r_out_last <= r_rd_last;
            end else if (w_xfer) begin
                o_valid    <= 1'b0;
                r_out_last <= 1'b0;
            end

            if (w_xfer) begin
                r_xfer_cnt <= r_xfer_cnt + 1'b1;
            end

            // Completion seen early is remembered so WAIT_DONE can pass straight through
            if (w_restart) begin
                r_pending_done <= 1'b0;
            end else if (i_output_last && ((r_state == S_LOAD) || (r_state == S_SEND))) begin
                r_pending_done <= 1'b1;
            end

            // Fresh frame: rewind pointers and counters
            if (w_restart) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_wr_cnt    <= '0;
                r_issue_cnt <= '0;
                r_xfer_cnt  <= '0;
            end
        end
    end

`ifdef TASK_IN_FRAME_BUFFER_LAST_EN
    assign o_last = r_out_last;
`else
    logic w_unused;
    assign w_unused = r_out_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_task_in_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_task_in_frame_buffer
// Description : Directed self-checking bench for task_in_frame_buffer with a
//               scoreboard queue of expected output beats (DEPTH=6).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_task_in_frame_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 6;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tvalid = 1'b0;
    logic [DW-1:0]    tdata = '0;
    logic             tlast = 1'b0;
    logic             ready = 1'b1;
    logic             output_last = 1'b0;
    logic             tready;
    logic             valid;
    logic [DW-1:0]    data;
    logic [CNT_W-1:0] frame_len;
    logic             overflow;
    logic             busy;
`ifdef TASK_IN_FRAME_BUFFER_LAST_EN
    logic             last;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW:0] exp_q [$];
    logic [DW:0] e_beat;
    logic        prev_stall = 1'b0;
    logic [DW-1:0] held_data = '0;

    task_in_frame_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_tvalid      (tvalid),
        .i_tdata       (tdata),
        .i_tlast       (tlast),
        .o_tready      (tready),
        .o_valid       (valid),
        .o_data        (data),
        .i_ready       (ready),
        .i_output_last (output_last),
        .o_frame_len   (frame_len),
        .o_overflow    (overflow),
        .o_busy        (busy)
`ifdef TASK_IN_FRAME_BUFFER_LAST_EN
        ,
        .o_last        (last)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pops on each transfer, hold check under stall
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(valid), 32'd1);
                check("hold_data", 32'(data), 32'(held_data));
            end
            if (valid && ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat: observed data=%0h expected none", data);
                end
                if (exp_q.size() != 0) begin
                    e_beat = exp_q.pop_front();
                    check("out_data", 32'(data), 32'(e_beat[DW-1:0]));
`ifdef TASK_IN_FRAME_BUFFER_LAST_EN
                    check("out_last", 32'(last), 32'(e_beat[DW]));
`endif
                end
            end
`ifdef TASK_IN_FRAME_BUFFER_LAST_EN
            if (!valid) begin
                check("last_idle", 32'(last), 32'd0);
            end
`endif
            prev_stall <= valid && !ready;
            held_data  <= data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [DW-1:0] d, input logic l);
        int n = 0;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        forever begin
            @(negedge clk);
            if (tready) break;
            n++;
            if (n > 50) begin
                check("accept_timeout", 32'(n), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input int n);
        int kept = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < kept; i++) begin
            exp_q.push_back({(i == kept - 1), DW'(base + i)});
        end
        for (int i = 0; i < n; i++) begin
            push_beat(DW'(base + i), (i == n - 1));
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || valid) && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 200), 32'd1);
    endtask

    task automatic wait_tready(input int limit, input string tag);
        int n = 0;
        while (!tready && n < limit) begin
            tick();
            n++;
        end
        check(tag, 32'(tready), 32'd1);
    endtask

    task automatic finish_frame();
        output_last = 1'b1;
        tick();
        output_last = 1'b0;
        wait_tready(5, "done_return");
    endtask

    initial begin
        logic [3:0] pat;
        int k;
        pat = 4'b1001;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_tready", 32'(tready), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_frame_len", 32'(frame_len), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        check("tready_after_rst", 32'(tready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Five-beat frame, latency of first output beat
        send_frame(8'h11, 5);
        check("f1_tready_drop", 32'(tready), 32'd0);
        check("f1_valid_t0", 32'(valid), 32'd0);
        check("f1_frame_len", 32'(frame_len), 32'd5);
        check("f1_overflow", 32'(overflow), 32'd0);
        check("f1_busy", 32'(busy), 32'd1);
        tick();
        check("f1_valid_t1", 32'(valid), 32'd0);
        tick();
        check("f1_valid_t2", 32'(valid), 32'd1);
        wait_drain("f1_drain");
        finish_frame();

        // Overflow: eight beats into six-deep buffer
        send_frame(8'h01, 8);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_frame_len", 32'(frame_len), 32'(DEPTH));
        wait_drain("ovf_drain");
        check("ovf_sticky", 32'(overflow), 32'd1);
        finish_frame();
        exp_q.push_back({1'b0, 8'h31});
        exp_q.push_back({1'b0, 8'h32});
        exp_q.push_back({1'b1, 8'h33});
        push_beat(8'h31, 1'b0);
        check("ovf_clear", 32'(overflow), 32'd0);
        push_beat(8'h32, 1'b0);
        push_beat(8'h33, 1'b1);
        check("f3_frame_len", 32'(frame_len), 32'd3);
        wait_drain("f3_drain");
        finish_frame();

        // Exactly DEPTH beats replayed under toggling backpressure
        send_frame(8'h41, 6);
        check("bp_frame_len", 32'(frame_len), 32'd6);
        check("bp_overflow", 32'(overflow), 32'd0);
        k = 0;
        while ((exp_q.size() != 0 || valid) && k < 200) begin
            ready = pat[k % 4];
            tick();
            k++;
        end
        check("bp_drain", 32'(k < 200), 32'd1);
        ready = 1'b1;
        finish_frame();

        // Completion pulse during replay returns straight to LOAD
        send_frame(8'hA0, 4);
        k = 0;
        while (!valid && k < 10) begin
            tick();
            k++;
        end
        check("pend_valid_seen", 32'(valid), 32'd1);
        output_last = 1'b1;
        tick();
        output_last = 1'b0;
        wait_drain("pend_drain");
        wait_tready(3, "pend_return");

        // Reset in the middle of a frame
        push_beat(8'h91, 1'b0);
        push_beat(8'h92, 1'b0);
        push_beat(8'h93, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        wait_tready(5, "mid_rst_ready");
        send_frame(8'h55, 1);
        wait_drain("mid_rst_drain_a");
        // 0x55 alone here would be a one-beat frame; redo with 0x55,0x66
        finish_frame();
        exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b1, 8'h66});
        push_beat(8'h55, 1'b0);
        push_beat(8'h66, 1'b1);
        check("mid_rst_frame_len", 32'(frame_len), 32'd2);
        wait_drain("mid_rst_drain");
        finish_frame();

        // Single-beat frame
        send_frame(8'h7E, 1);
        check("single_frame_len", 32'(frame_len), 32'd1);
        wait_drain("single_drain");
        finish_frame();

        repeat (3) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
